// File: rtl/id_decode_reg_if.sv
// IF/ID decode-stage bundle: fetch handshake in, registered decode fields out.
// The master side is the fetch/hazard logic and the slave side is the decode register.
interface id_decode_reg_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            id_stall;
    logic            id_flush;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic [2:0]      exten_sel;
    logic [24:0]     imm_in;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_imm;
    logic            illegal;

    modport master (
        output if_valid, if_instr, if_pc, id_stall, id_flush,
        input  if_ready, id_valid, id_instr, id_pc, id_pc_plus4, exten_sel,
               imm_in, rs1, rs2, rd, uses_imm, illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, id_stall, id_flush,
        output if_ready, id_valid, id_instr, id_pc, id_pc_plus4, exten_sel,
               imm_in, rs1, rs2, rd, uses_imm, illegal
    );
endinterface

// File: rtl/id_decode_reg.sv
// Registered IF/ID stage: captures instruction/PC and pre-decodes the immediate
// extension select so the sign-extension unit can start in the next cycle.
module id_decode_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input logic          clk,
    input logic          rst,
    id_decode_reg_if.slave bus
);
    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_S = 3'b001,
        EXT_B = 3'b010,
        EXT_U = 3'b011,
        EXT_J = 3'b100
    } ext_sel_t;

    logic [6:0] opcode;
    ext_sel_t   dec_sel;
    logic       dec_uses_imm;
    logic       dec_illegal;

    assign opcode      = bus.if_instr[6:0];
    assign bus.if_ready = ~bus.id_stall;

    always_comb begin
        dec_sel      = EXT_I;
        dec_uses_imm = 1'b1;
        dec_illegal  = 1'b0;
        unique case (opcode)
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: dec_sel = EXT_I;
            7'b0100011:             dec_sel = EXT_S;
            7'b1100011:             dec_sel = EXT_B;
            7'b0110111, 7'b0010111: dec_sel = EXT_U;
            7'b1101111:             dec_sel = EXT_J;
            7'b0110011:             dec_uses_imm = 1'b0;
            default: begin
                dec_uses_imm = 1'b0;
                dec_illegal  = 1'b1;
            end
        endcase
    end

    // Bubble contents are the NOP's own decode, so consumers see a consistent addi x0,x0,0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.id_valid    <= 1'b0;
            bus.id_instr    <= NOP_INSTR;
            bus.id_pc       <= '0;
            bus.id_pc_plus4 <= XLEN'(4);
            bus.exten_sel   <= EXT_I;
            bus.imm_in      <= NOP_INSTR[31:7];
            bus.rs1         <= NOP_INSTR[19:15];
            bus.rs2         <= NOP_INSTR[24:20];
            bus.rd          <= NOP_INSTR[11:7];
            bus.uses_imm    <= 1'b1;
            bus.illegal     <= 1'b0;
        end else if (bus.id_flush || (!bus.id_stall && !bus.if_valid)) begin
            bus.id_valid    <= 1'b0;
            bus.id_instr    <= NOP_INSTR;
            bus.exten_sel   <= EXT_I;
            bus.imm_in      <= NOP_INSTR[31:7];
            bus.rs1         <= NOP_INSTR[19:15];
            bus.rs2         <= NOP_INSTR[24:20];
            bus.rd          <= NOP_INSTR[11:7];
            bus.uses_imm    <= 1'b1;
            bus.illegal     <= 1'b0;
        end else if (!bus.id_stall) begin
            bus.id_valid    <= 1'b1;
            bus.id_instr    <= bus.if_instr;
            bus.id_pc       <= bus.if_pc;
            bus.id_pc_plus4 <= bus.if_pc + XLEN'(4);
            bus.exten_sel   <= dec_sel;
            bus.imm_in      <= bus.if_instr[31:7];
            bus.rs1         <= bus.if_instr[19:15];
            bus.rs2         <= bus.if_instr[24:20];
            bus.rd          <= bus.if_instr[11:7];
            bus.uses_imm    <= dec_uses_imm;
            bus.illegal     <= dec_illegal;
        end
    end
endmodule

// File: doc/id_decode_reg.md
Name: id_decode_reg

Overview:
- Registered IF/ID decode stage directly upstream of the immediate sign-extension unit.
- Captures the fetched instruction and PC, and decodes the opcode into the 3-bit extension-select code.
- Slices the 25-bit immediate field instr[31:7] and the register indices.
- Outputs are registered and feed the extension unit, the register file and the ID/EX register in the next cycle; the block supports stall (hold) and flush (bubble).

Parameters:
- XLEN, 32, instruction and PC width.
- NOP_INSTR, 32'h00000013, instruction word loaded on flush/bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- if_valid  input  1  fetch stage presents a valid instruction
- if_instr  input  XLEN  fetched instruction word
- if_pc  input  XLEN  PC of if_instr
- if_ready  output  1  stage can accept; combinational, = ~id_stall
- id_stall  input  1  hazard unit: hold current contents
- id_flush  input  1  branch/jump redirect: kill current contents
- id_valid  output  1  registered instruction is valid
- id_instr  output  XLEN  registered instruction
- id_pc  output  XLEN  registered PC
- id_pc_plus4  output  XLEN  registered if_pc+4, modulo 2^XLEN
- exten_sel  output  3  000 I, 001 S, 010 B, 011 U, 100 J
- imm_in  output  25  registered instr[31:7]
- rs1  output  5  instr[19:15]
- rs2  output  5  instr[24:20]
- rd  output  5  instr[11:7]
- uses_imm  output  1  instruction consumes the extended immediate
- illegal  output  1  opcode not in supported set, gated by id_valid

Behaviour:
- Single clock domain. Update priority each rising edge: rst > id_flush > id_stall > load.
- Reset: id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4, exten_sel=000, imm_in=instr[31:7] of NOP (25'h0000000), rs1=rs2=rd=0, uses_imm=1, illegal=0.
- Flush: same values as reset except id_pc and id_pc_plus4 hold. Flush overrides a simultaneous stall.
- Stall (no flush): every output register holds. if_ready=0 in that cycle; fetch must hold its inputs.
- Load (no stall, no flush):
  - if_valid=1: capture if_instr/if_pc, set id_valid=1, and decode.
  - if_valid=0: load a bubble (NOP_INSTR, id_valid=0, id_pc holds).
- Latency: exactly 1 cycle from if_* to id_* when not stalled.
- Decode on opcode = instr[6:0]:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM → 000, uses_imm=1.
  - 0100011 STORE → 001, uses_imm=1.
  - 1100011 BRANCH → 010, uses_imm=1.
  - 0110111 LUI, 0010111 AUIPC → 011, uses_imm=1.
  - 1101111 JAL → 100, uses_imm=1.
  - 0110011 OP → 000, uses_imm=0.
  - Any other opcode → 000, uses_imm=0, illegal=1 (only when captured with if_valid=1).
- Decode is computed from if_instr before the register, so all outputs are mutually consistent in the same cycle.
- Field slicing is unconditional, so rs1/rs2/rd reflect raw bits even for U/J types. Consumers qualify with opcode.
- id_pc_plus4 wraps: if_pc=32'hFFFFFFFC gives 0.
- rst asserted mid-stall clears immediately at the next edge; stall has no effect while rst=1.
- No internal state beyond the output registers.

Test Plan:
- Reset with rst=1 for 2 cycles, then rst=0 with if_valid=0 → id_valid=0, id_instr=0x00000013, exten_sel=000, id_pc=0, id_pc_plus4=4, illegal=0.
- Load if_instr=0xFFF00093, if_pc=0x100, if_valid=1 → next cycle: id_valid=1, exten_sel=000, imm_in=25'h1FFE001, rd=1, rs1=0, uses_imm=1, id_pc_plus4=0x104.
- Back-to-back loads 0x0020A423 (sw), 0xFE000EE3 (beq), 0x000012B7 (lui), 0x008000EF (jal):
  - exten_sel sequence 001, 010, 011, 100 on consecutive cycles.
  - sw gives rs1=1, rs2=2.
  - jal gives rd=1.
- Hold id_stall=1 for 3 cycles while if_instr changes → outputs frozen at the prior value and if_ready=0 throughout. Releasing the stall loads the instruction present at release.
- Assert id_flush and id_stall together with a valid instruction held → next cycle id_valid=0, id_instr=0x00000013, id_pc unchanged.
- Load opcode 0x7F (if_instr=0x0000007F) → illegal=1, uses_imm=0. Load if_pc=0xFFFFFFFC → id_pc_plus4=0.
